// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding,
// default operand width and a one-bit full-subtract reference function.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One full-subtract step; returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    logic x;
    x = a ^ b;
    return {(~a & b) | (~x & bin), x ^ bin};
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: difference and borrow of A - B for one bit.
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B;
  assign Bo = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first over WIDTH cycles, with a
// start/done handshake. One full-subtractor slice is built from two half subtractors.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    count;
  logic             borrow;

  logic hs0_d, hs0_bo, hs1_bo, diff_bit, borrow_next;

  half_subtractor u_hs0 (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .D  (hs0_d),
    .Bo (hs0_bo)
  );

  half_subtractor u_hs1 (
    .A  (hs0_d),
    .B  (borrow),
    .D  (diff_bit),
    .Bo (hs1_bo)
  );

  assign borrow_next = hs0_bo | hs1_bo;

  // NOTE: every register here, shift registers included, is in the async reset so an
  // aborted operation leaves no stale partial result behind; state updates use <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      borrow     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      D          <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= {diff_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_next;
          // Hold count at its terminal value instead of letting it wrap.
          if (count == LAST) begin
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          D          <= res_sr;
          borrow_out <= borrow;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16: directed
// cases, back-to-back start, mid-operation reset, and a randomized sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bo8;
  logic [7:0]  d8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bo16;
  logic [15:0] d16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .D(d16), .borrow_out(bo16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = s; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic [31:0] get_d(input int w);
    return (w == 8) ? {24'b0, d8} : {16'b0, d16};
  endfunction

  function automatic logic get_bo(input int w);
    return (w == 8) ? bo8 : bo16;
  endfunction

  // Reference: plain modular arithmetic and unsigned compare.
  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // One operation with a single-cycle start; checks latency, busy, hold and result.
  task automatic do_op(input string tag, input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_d, prev_d;
    logic        exp_bo;
    int          lat;
    exp_d  = (a - b) & mask_of(w);
    exp_bo = ((a & mask_of(w)) < (b & mask_of(w)));
    lat    = -1;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    prev_d = get_d(w);
    drive(w, 1'b0, $urandom, $urandom);
    for (int k = 0; k <= w + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 3 == 1) drive(w, 1'b0, $urandom, $urandom);
      if (get_done(w) && lat < 0) lat = k;
      if (k == 0)     check({tag, " busy_start"}, 32'(get_busy(w)), 32'd1);
      if (k == w)     check({tag, " d_held"}, get_d(w), prev_d);
      if (k == w + 1) check({tag, " busy_done"}, 32'(get_busy(w)), 32'd1);
      if (k == w + 2) begin
        check({tag, " busy_idle"}, 32'(get_busy(w)), 32'd0);
        check({tag, " done_1cyc"}, 32'(get_done(w)), 32'd0);
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(w + 1));
    check({tag, " D"}, get_d(w), exp_d);
    check({tag, " borrow"}, 32'(get_bo(w)), 32'(exp_bo));
  endtask

  initial begin
    int          times[$];
    logic [31:0] ds[$];
    logic        bos[$];
    int          seen;

    #1;
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst D", 32'(d8), 32'd0);
    check("rst borrow", 32'(bo8), 32'd0);
    check("rst D16", 32'(d16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases at WIDTH=8.
    do_op("5-3", 8, 5, 3);
    do_op("3-5", 8, 3, 5);
    do_op("0-0", 8, 0, 0);
    do_op("FF-1", 8, 32'hFF, 32'h01);
    do_op("0-FF", 8, 32'h00, 32'hFF);

    // Back-to-back with start held high; A/B wander while busy.
    @(negedge clk);
    drive(8, 1'b1, 9, 4);
    @(posedge clk);
    for (int k = 0; k <= 2 * 8 + 6; k++) begin
      @(negedge clk);
      if (k == 0) drive(8, 1'b1, $urandom, $urandom);
      if (k == 4) drive(8, 1'b1, $urandom, $urandom);
      if (k == 8 + 1) drive(8, 1'b1, 1, 2);
      if (k == 8 + 2) drive(8, 1'b0, $urandom, $urandom);
      if (done8) begin
        times.push_back(k);
        ds.push_back({24'b0, d8});
        bos.push_back(bo8);
      end
    end
    check("b2b pulses", 32'(times.size()), 32'd2);
    if (times.size() >= 2) begin
      check("b2b first_lat", 32'(times[0]), 32'd9);
      check("b2b spacing", 32'(times[1] - times[0]), 32'd10);
      check("b2b D0", ds[0], 32'h05);
      check("b2b bo0", 32'(bos[0]), 32'd0);
      check("b2b D1", ds[1], 32'hFF);
      check("b2b bo1", 32'(bos[1]), 32'd1);
    end

    // Reset asserted in the middle of an operation.
    @(negedge clk);
    drive(8, 1'b1, 5, 3);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort D", 32'(d8), 32'd0);
    check("abort borrow", 32'(bo8), 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check("abort no_done", 32'(seen), 32'd0);
    do_op("7-7", 8, 7, 7);

    // Randomized sweeps.
    for (int i = 0; i < 1000; i++) do_op("rnd8", 8, $urandom & 32'hFF, $urandom & 32'hFF);
    do_op("16 max-1", 16, 32'hFFFF, 32'h0001);
    do_op("16 0-1", 16, 32'h0000, 32'h0001);
    for (int i = 0; i < 1000; i++) do_op("rnd16", 16, $urandom & 32'hFFFF, $urandom & 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
